cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer for the CP0 register file.
- Sits beside the MEM stage. Prioritises exceptions, interrupts and ERET reported by the instruction in MEM.
- Issues the one-cycle CP0 update commands (EPC/Cause/Status/BadVAddr) and flushes the pipeline.
- Hands the fetch unit a redirect PC over a valid/ready handshake. Also synchronises the six raw hardware interrupt lines into CP0.

Parameters:
EXC_ENTRY, 32'hBFC00380, exception vector driven on redirect_pc for all exceptions and interrupts.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
interrupt  in  6  raw asynchronous hardware interrupt lines
mem_valid  in  1  MEM stage holds a valid instruction
mem_pc  in  32  PC of the MEM instruction
mem_delay_slot  in  1  MEM instruction sits in a branch delay slot
mem_exc_flags  in  7  [0] AdEL fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL data, [6] AdES
mem_addr  in  32  data address of the MEM load/store
mem_eret  in  1  MEM instruction is ERET
cp0_status  in  32  Status: bit0 IE, bit1 EXL, [15:8] IM
cp0_cause_sw_ip  in  2  Cause.IP[1:0] (software interrupts)
cp0_epc  in  32  current EPC
cp0_hw_ip  out  6  synchronised interrupts, to Cause.IP[7:2]
cp0_exc_we  out  1  pulse: set EXL, write ExcCode/BD/EPC
cp0_exc_code  out  5  ExcCode
cp0_exc_bd  out  1  Cause.BD
cp0_exc_epc  out  32  EPC value
cp0_badvaddr_we  out  1  pulse: write BadVAddr
cp0_badvaddr  out  32  BadVAddr value
cp0_eret_we  out  1  pulse: clear EXL
flush  out  1  kill IF..MEM contents
busy  out  1  stall request to pipeline
redirect_valid  out  1  redirect PC offered to fetch
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (rst low, async):
  - state IDLE.
  - All outputs 0, including the synchroniser flops.
  - Reset during COMMIT/REDIRECT abandons the sequence; no redirect is issued.
- Interrupt synchroniser:
  - Two flops per line, plain 2-FF, no edge detection.
  - cp0_hw_ip equals interrupt delayed by 2 clk edges.
- int_pend = IE & ~EXL & |(status[15:8] & {cp0_hw_ip, cp0_cause_sw_ip}).
- Trigger, evaluated in IDLE only: mem_valid & (int_pend | |mem_exc_flags | mem_eret).
  - Without mem_valid nothing is taken; a pending interrupt waits for the next valid instruction, so EPC stays precise.
- Priority, highest first, single winner:
  - Int 0x00
  - AdEL fetch 0x04
  - RI 0x0A
  - Ov 0x0C
  - Sys 0x08
  - Bp 0x09
  - AdEL data 0x04
  - AdES 0x05
  - ERET
- EPC/BD:
  - mem_delay_slot=1: EPC = mem_pc - 4 (mod 2^32), BD = 1.
  - Otherwise EPC = mem_pc, BD = 0.
  - Interrupts use the same rule; the MEM instruction is not committed.
- BadVAddr:
  - AdEL fetch: mem_pc.
  - AdEL/AdES data: mem_addr.
  - Other winners: no BadVAddr write.
- Targets: exceptions → EXC_ENTRY; ERET → cp0_epc sampled at the trigger cycle.
- Decode results and target are registered at the trigger edge.
- States:
  - IDLE: all pulses 0, busy 0, flush 0. On trigger at cycle T → COMMIT.
  - COMMIT (T+1, exactly one cycle):
    - Exception: cp0_exc_we=1, plus cp0_badvaddr_we if applicable.
    - ERET: cp0_eret_we=1 only.
    - flush=1, busy=1 → REDIRECT.
  - REDIRECT (T+2 onward):
    - redirect_valid=1, redirect_pc stable, flush=1, busy=1.
    - On redirect_valid & redirect_ready → IDLE; outputs drop on the next cycle.
    - redirect_ready low holds the state indefinitely.
- Triggers during COMMIT/REDIRECT are ignored; the pipeline is being flushed.
- A new trigger is accepted in the first IDLE cycle after the handshake.
- cp0_exc_code, cp0_exc_bd, cp0_exc_epc and cp0_badvaddr hold their last latched value outside COMMIT; only the _we pulses qualify them.
- Minimum sequence is 3 cycles (trigger, COMMIT, REDIRECT accepted immediately).

Test Plan:
1. Syscall, mem_pc=0xBFC00100, no delay slot, redirect_ready=1 → T+1: exc_we=1, code 0x08, epc 0xBFC00100, bd 0, no badvaddr_we. T+2: redirect_valid=1, redirect_pc 0xBFC00380. Flush high T+1..T+2, low T+3.
2. Ov in delay slot, mem_pc=0x80001004 → code 0x0C, epc 0x80001000, bd 1. mem_pc=0x00000000 in delay slot → epc 0xFFFFFFFC.
3. AdES with mem_addr=0x00000003 → code 0x05, badvaddr_we=1, badvaddr 0x3. AdEL fetch + RI together at mem_pc=0x80000002 → code 0x04, badvaddr 0x80000002.
4. interrupt[2]↑ with IE=1, EXL=0, status[12]=1 → cp0_hw_ip[2]=1 after 2 edges; next valid instruction at 0x80000040 with a Sys flag set → code 0x00, epc 0x80000040. Same case with EXL=1 → no trigger; Sys is taken instead, code 0x08.
5. ERET with cp0_epc=0x80000200 → cp0_eret_we pulse, exc_we=0, redirect_pc 0x80000200.
6. Stall and reset:
   - redirect_ready low for 3 cycles → redirect_valid/flush/busy held 3 cycles, a Syscall presented meanwhile is ignored, accept → IDLE.
   - rst low mid-REDIRECT → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_exc_ctrl_if.sv
// Redirect handshake between the exception sequencer and the fetch unit.
//   redirect_valid : sequencer offers a new fetch PC
//   redirect_pc    : target PC, stable while redirect_valid is high
//   redirect_ready : fetch accepts the redirect this cycle
// master = sequencer side, slave = fetch side.
interface cp0_exc_ctrl_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   modport master (
      output redirect_valid,
      output redirect_pc,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid,
      input  redirect_pc,
      output redirect_ready
   );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt sequencer for the CP0 register file, sitting beside MEM.
// Picks one winner among interrupt, exceptions and ERET for the MEM instruction,
// issues one-cycle CP0 update pulses, flushes the pipeline and hands fetch a
// redirect PC over the redir handshake. Also 2-FF synchronises the hardware
// interrupt lines into Cause.IP[7:2].
// Ports:
//   clk, rst                  clock, async active-low reset
//   interrupt                 raw hardware interrupt lines
//   mem_*                     MEM-stage instruction info (valid, pc, BD, flags, addr, eret)
//   cp0_status/sw_ip/epc      current CP0 state
//   cp0_hw_ip                 synchronised interrupts
//   cp0_exc_*/cp0_badvaddr*   exception commit command and data
//   cp0_eret_we               clear-EXL pulse
//   flush, busy               pipeline kill and stall
//   redir                     redirect handshake to fetch (master side)
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC00380
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            interrupt,
   input  logic                  mem_valid,
   input  logic [31:0]           mem_pc,
   input  logic                  mem_delay_slot,
   input  logic [6:0]            mem_exc_flags,
   input  logic [31:0]           mem_addr,
   input  logic                  mem_eret,
   input  logic [31:0]           cp0_status,
   input  logic [1:0]            cp0_cause_sw_ip,
   input  logic [31:0]           cp0_epc,
   output logic [5:0]            cp0_hw_ip,
   output logic                  cp0_exc_we,
   output logic [4:0]            cp0_exc_code,
   output logic                  cp0_exc_bd,
   output logic [31:0]           cp0_exc_epc,
   output logic                  cp0_badvaddr_we,
   output logic [31:0]           cp0_badvaddr,
   output logic                  cp0_eret_we,
   output logic                  flush,
   output logic                  busy,
   cp0_exc_ctrl_if.master        redir
);

   typedef enum logic [1:0] {StIdle, StCommit, StRedirect} state_e;

   state_e      state_q, state_d;
   logic [5:0]  int_meta_q, hw_ip_q;
   logic        int_pend, trigger;
   logic [4:0]  dec_code;
   logic        dec_bv_we, dec_eret;
   logic [31:0] dec_bv, dec_epc;
   logic [4:0]  code_q;
   logic        bd_q, eret_q, bv_we_q;
   logic [31:0] epc_q, bv_q, target_q;
   logic        redirect_valid;
   logic        unused_status;

   assign unused_status = ^{cp0_status[31:16], cp0_status[7:2]};

   // Plain 2-FF synchroniser, no edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_meta_q <= '0;
         hw_ip_q    <= '0;
      end else begin
         int_meta_q <= interrupt;
         hw_ip_q    <= int_meta_q;
      end
   end

   assign cp0_hw_ip = hw_ip_q;
   assign int_pend  = cp0_status[0] & ~cp0_status[1] &
                      (|(cp0_status[15:8] & {hw_ip_q, cp0_cause_sw_ip}));
   // Interrupts wait for a valid MEM instruction so EPC is precise.
   assign trigger   = (state_q == StIdle) & mem_valid &
                      (int_pend | (|mem_exc_flags) | mem_eret);
   assign dec_epc   = mem_delay_slot ? (mem_pc - 32'd4) : mem_pc;

   // Single-winner priority decode.
   always_comb begin
      dec_code  = 5'h00;
      dec_bv_we = 1'b0;
      dec_bv    = mem_addr;
      dec_eret  = 1'b0;
      if (int_pend) begin
         dec_code = 5'h00;
      end else if (mem_exc_flags[0]) begin
         dec_code  = 5'h04;
         dec_bv_we = 1'b1;
         dec_bv    = mem_pc;
      end else if (mem_exc_flags[1]) begin
         dec_code = 5'h0A;
      end else if (mem_exc_flags[2]) begin
         dec_code = 5'h0C;
      end else if (mem_exc_flags[3]) begin
         dec_code = 5'h08;
      end else if (mem_exc_flags[4]) begin
         dec_code = 5'h09;
      end else if (mem_exc_flags[5]) begin
         dec_code  = 5'h04;
         dec_bv_we = 1'b1;
      end else if (mem_exc_flags[6]) begin
         dec_code  = 5'h05;
         dec_bv_we = 1'b1;
      end else begin
         dec_eret = 1'b1;
      end
   end

   // Commit data is latched only at the trigger edge and otherwise held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code_q   <= '0;
         bd_q     <= 1'b0;
         epc_q    <= '0;
         bv_q     <= '0;
         bv_we_q  <= 1'b0;
         eret_q   <= 1'b0;
         target_q <= '0;
      end else if (trigger) begin
         eret_q   <= dec_eret;
         bv_we_q  <= dec_bv_we;
         target_q <= dec_eret ? cp0_epc : EXC_ENTRY;
         if (!dec_eret) begin
            code_q <= dec_code;
            bd_q   <= mem_delay_slot;
            epc_q  <= dec_epc;
         end
         if (dec_bv_we) begin
            bv_q <= dec_bv;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cp0_exc_we      = 1'b0;
      cp0_eret_we     = 1'b0;
      cp0_badvaddr_we = 1'b0;
      flush           = 1'b0;
      busy            = 1'b0;
      redirect_valid  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (trigger) state_d = StCommit;
         end
         StCommit: begin
            cp0_exc_we      = ~eret_q;
            cp0_eret_we     = eret_q;
            cp0_badvaddr_we = bv_we_q & ~eret_q;
            flush           = 1'b1;
            busy            = 1'b1;
            state_d         = StRedirect;
         end
         StRedirect: begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            busy           = 1'b1;
            if (redir.redirect_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign cp0_exc_code         = code_q;
   assign cp0_exc_bd           = bd_q;
   assign cp0_exc_epc          = epc_q;
   assign cp0_badvaddr         = bv_q;
   assign redir.redirect_valid = redirect_valid;
   assign redir.redirect_pc    = target_q;

endmodule
